// File: rtl/argmax_tree_pipe.sv
// Pipelined argmax over P_N unsigned channels using a registered binary comparison tree.
// Optional threshold gate on the winner is enabled by defining ARGMAX_THRESH_EN.
module argmax_tree_pipe #(
  parameter int  P_WIDTH = 19,
  parameter int  P_N     = 8,
  localparam int P_IW    = $clog2(P_N)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [P_N*P_WIDTH-1:0] i_data,
`ifdef ARGMAX_THRESH_EN
  input  logic [P_WIDTH-1:0]     i_thresh,
`endif
  output logic                   o_valid,
  output logic [P_WIDTH-1:0]     o_result,
  output logic [P_N-1:0]         o_index,
  output logic [P_IW-1:0]        o_index_bin,
  output logic                   o_none
);

  localparam int LVLS = P_IW;
  localparam int NP   = 1 << P_IW;
  localparam int NN   = NP - 1;
  localparam int PADW = NP * P_WIDTH;

  typedef struct packed {
    logic [P_WIDTH-1:0] val;
    logic [P_IW-1:0]    idx;
    logic               nz;
  } cand_t;

  logic [PADW-1:0] data_pad;
  // Leaves occupy 0..NP-1, registered nodes follow; node j compares tree[2j] and tree[2j+1].
  cand_t           tree   [2*NP-2];
  cand_t           node_d [NN];
  cand_t           node_q [NN];
  logic [NN-1:0]   node_en;
  logic [LVLS-1:0] stage_en;
  logic [LVLS-1:0] vld_q;
  cand_t           fin;
  logic            none;
  logic [P_N-1:0]  one_hot;

  // Padding channels read as zero and carry the highest indices, so they lose every tie.
  assign data_pad = PADW'(i_data);

  always_comb begin : build_tree
    for (int c = 0; c < NP; c++) begin
      tree[c].val = data_pad[c*P_WIDTH +: P_WIDTH];
      tree[c].idx = P_IW'(c);
      tree[c].nz  = |data_pad[c*P_WIDTH +: P_WIDTH];
    end
    for (int c = 0; c < NN - 1; c++) begin
      tree[NP + c] = node_q[c];
    end
  end

  always_comb begin : compare
    for (int j = 0; j < NN; j++) begin
      node_d[j]    = (tree[2*j].val >= tree[2*j+1].val) ? tree[2*j] : tree[2*j+1];
      node_d[j].nz = tree[2*j].nz | tree[2*j+1].nz;
    end
  end

  always_comb begin : enables
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    stage_en    = '0;
    stage_en[0] = i_valid;
    for (int l = 1; l < LVLS; l++) begin
      stage_en[l] = vld_q[l-1];
    end
    node_en = '0;
    for (int j = 0; j < NN; j++) begin
      for (int l = 0; l < LVLS; l++) begin
        if (j >= NP - (NP >> l) && j < NP - (NP >> (l + 1))) begin
          node_en[j] = stage_en[l];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      // NOTE: data registers are reset as well so the idle outputs read zero / no-winner.
      for (int j = 0; j < NN; j++) begin
        node_q[j] <= '0;
      end
    end else begin
      // NOTE: sequential state is only ever updated with non-blocking assignments.
      vld_q <= stage_en;
      for (int j = 0; j < NN; j++) begin
        if (node_en[j]) begin
          node_q[j] <= node_d[j];
        end
      end
    end
  end

  assign fin = node_q[NN-1];

`ifdef ARGMAX_THRESH_EN
  logic [P_WIDTH-1:0] thresh_q [LVLS];

  // Threshold travels with its beat so a mid-stream change only affects later beats.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int l = 0; l < LVLS; l++) begin
        thresh_q[l] <= '0;
      end
    end else begin
      if (stage_en[0]) begin
        thresh_q[0] <= i_thresh;
      end
      for (int l = 1; l < LVLS; l++) begin
        if (stage_en[l]) begin
          thresh_q[l] <= thresh_q[l-1];
        end
      end
    end
  end

  assign none = !fin.nz || (fin.val < thresh_q[LVLS-1]);
`else
  assign none = !fin.nz;
`endif

  assign one_hot     = P_N'(1) << fin.idx;
  assign o_valid     = vld_q[LVLS-1];
  assign o_result    = fin.val;
  assign o_index_bin = none ? '0 : fin.idx;
  assign o_index     = none ? '0 : one_hot;
  assign o_none      = none;

endmodule

// File: doc/argmax_tree_pipe.md
# argmax_tree_pipe

Pipelined, parametrised argmax unit: takes `P_N` unsigned `P_WIDTH`-bit channel values per valid beat and returns the maximum value and its winning channel index. Index is returned both one-hot and binary. One beat is accepted per clock through a registered binary comparison tree. It is the next generation of the six-input output-layer comparator in the classifier datapath, and it sits between the neuron-potential bank and the label/decision logic. Channel count is now generic, the design is fully pipelined with valid tagging, and an optional threshold gate is available.

## Interface
Parameters:
- `P_WIDTH`, 19: bit width of each channel value (unsigned).
- `P_N`, 8: number of channels, 2..64.
- `P_IW`, `$clog2(P_N)`: binary index width (localparam).

Ports:
- `i_clk`, in, 1: single clock, rising edge.
- `i_rst_n`, in, 1: reset, synchronous and active-low.
- `i_valid`, in, 1: `i_data` is a valid beat this cycle.
- `i_data`, in, `P_N*P_WIDTH`: channel k at bits `[k*P_WIDTH +: P_WIDTH]`.
- `i_thresh`, in, `P_WIDTH`: minimum winning value. Present only with `ARGMAX_THRESH_EN`.
- `o_valid`, out, 1: result beat valid.
- `o_result`, out, `P_WIDTH`: maximum channel value.
- `o_index`, out, `P_N`: one-hot winning channel; all-zero means no winner.
- `o_index_bin`, out, `P_IW`: binary winner index; 0 when there is no winner.
- `o_none`, out, 1: no winner (all channels zero, or below threshold).

## Operation
- Tree depth `L = P_IW` levels. Level 0 compares pairs (2k, 2k+1); each level halves the candidate count.
- Every level's outputs are registered: value, binary index, and the OR-reduced "any nonzero" flag.
- Non-power-of-two `P_N`: pad to `2^P_IW` with value 0. Padded indices sit above all real indices.
- Pair rule: winner = left if left >= right, else right. The lowest index therefore wins every tie.
- No-winner condition:
  - Without the threshold feature: all real channels are zero. Then `o_index = 0`, `o_index_bin = 0`, `o_none = 1`, and `o_result` = 0.
  - With the threshold feature: the maximum is also below the threshold. `o_result` still carries the true maximum.
- `o_index` is decoded from the final binary index, gated by `!o_none`.
- Valid shift register: `L` bits, one per level, advancing unconditionally. There is no backpressure; the consumer must accept every beat.
- Data registers load only when their stage valid is set. When `o_valid` = 0, the outputs hold the last result.
- Arithmetic is unsigned compare only, with no width growth.

## Timing
- Latency: a beat sampled with `i_valid` = 1 at edge n appears with `o_valid` = 1 after edge n+L (P_N=8: 3 cycles; P_N=6: 3 cycles; P_N=2: 1 cycle).
- Throughput: 1 beat per cycle. Back-to-back beats emerge back-to-back, in order.
- Reset (`i_rst_n` = 0 at a rising edge):
  - Clears all valid bits, data registers, and index registers.
  - Sets `o_valid` = 0, `o_result` = 0, `o_index` = 0, `o_index_bin` = 0, `o_none` = 1.
  - Beats in flight are discarded.
  - The first edge with `i_rst_n` = 1 may accept a beat.
- `i_valid` together with reset: reset wins, and the beat is dropped.
- `i_thresh` is sampled with the beat at level 0 and pipelined alongside it. A threshold change mid-stream affects only beats sampled after the change.

## Configuration
- `ARGMAX_THRESH_EN` defined:
  - Adds port `i_thresh` and the pipelined threshold register.
  - `o_none` = 1 when max == 0 or max < the sampled threshold.
- Not defined:
  - No `i_thresh` port and no threshold logic.
  - `o_none` = 1 only when all channels are zero.

## Test plan
- P_N=8, W=19, single beat with ch3=500 and all others 100 -> after 3 cycles `o_valid`=1, `o_result`=500, `o_index`=8'b0000_1000, `o_index_bin`=3, `o_none`=0.
- Tie: ch1=ch5=ch6=700, others smaller -> `o_index_bin`=1 (lowest index wins).
- All channels 0 -> `o_result`=0, `o_index`=0, `o_index_bin`=0, `o_none`=1. P_N=6 with all zeros also gives `o_index_bin`=0 (padding never wins).
- Ten back-to-back beats with ch(k mod 8) = 1000+k -> ten consecutive `o_valid` cycles, in order, `o_index_bin` = k mod 8. Assert `i_rst_n`=0 for one cycle mid-stream -> `o_valid` goes low, outputs reset, and no stale beat appears afterward.
- `ARGMAX_THRESH_EN`, `i_thresh`=300, max ch2=299 -> `o_none`=1, `o_index`=0, `o_result`=299. With max ch2=300 -> `o_none`=0, `o_index_bin`=2.
- P_N=2, max value 2^19-1 on ch0 and ch1 -> latency 1, `o_index_bin`=0, `o_result`=19'h7FFFF.
